ren_wb_slave_fanout: RTL
========================

# ren_wb_slave_fanout

Parametrised Wishbone fan-out for the user area. It takes the single Wishbone slave port and routes each transfer to one of NO_OF_SLAVES accelerator instances (ren_conv_top or compatible) by address slot. Responses are registered, and a per-slave timeout returns an error response if a slave never acknowledges. A local CSR slot provides per-slave soft reset, sticky timeout status and an interrupt.

## Interface
Parameters:
- NO_OF_SLAVES, 11: number of downstream slaves, 1..15.
- SLV_SEL_LSB, 16: lowest wbs_adr_i bit of the slot field.
- SLV_SEL_WIDTH, 4: slot field width. Slot 2^SLV_SEL_WIDTH-1 is the CSR slot.
- TMO_WIDTH, 8: timeout counter width. The limit is 2^TMO_WIDTH-1 cycles.

Ports:
- wb_clk_i, in, 1: the single clock.
- wb_rst_i, in, 1: reset, asynchronous, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i, in, 1 each: host Wishbone control.
- wbs_sel_i, in, 4: byte selects.
- wbs_dat_i, in, 32: write data.
- wbs_adr_i, in, 32: address.
- wbs_ack_o, out, 1: registered acknowledge.
- wbs_dat_o, out, 32: registered read data.
- m_wbs_stb_o, out, NO_OF_SLAVES: one-hot strobe to the selected slave.
- m_wb_rst_o, out, NO_OF_SLAVES: active-high per-slave reset.
- m_wbs_ack_i, in, NO_OF_SLAVES: slave acknowledges.
- m_wbs_dat_i, in, 32*NO_OF_SLAVES: slave read data, flattened; slave i occupies [32i+31:32i].
- irq_o, out, 1: registered interrupt.

All other host signals (cyc, we, sel, dat, adr) go to every slave directly. Only stb is gated.

## Operation
- **slot** = wbs_adr_i[SLV_SEL_LSB +: SLV_SEL_WIDTH].
- **State machine** has three states: IDLE, WAIT, RESP.
- **IDLE**: when cyc&stb are high, latch slot and go to WAIT.
- **WAIT, slot < NO_OF_SLAVES**:
  - m_wbs_stb_o[slot] = 1 while cyc&stb remain high.
  - On m_wbs_ack_i[slot], latch that slave's data and go to RESP.
  - The timeout counter increments each WAIT cycle. At the limit, wbs_dat_o = 32'hDEAD_0000 | slot, STATUS[slot] is set, and the FSM goes to RESP.
- **WAIT, CSR slot**: one cycle, then RESP. Reads return the CSR value; writes update per byte under wbs_sel_i.
- **WAIT, unmapped slot** (NO_OF_SLAVES <= slot < CSR slot): no strobe is issued. wbs_dat_o = 32'hBADA_DD00 and the FSM goes to RESP. Writes are discarded.
- **RESP**: wbs_ack_o = 1 for exactly one cycle, then IDLE.
- **CSRs** (offset = wbs_adr_i[3:2]):
  - 0 RST_CTRL, reset 0: bit i drives the soft reset of slave i.
  - 1 STATUS: sticky timeout bits; write-1-to-clear.
  - 2 IRQ_EN: bit 0 only.
  - 3 ID: read-only, 32'h5245_4E00 | NO_OF_SLAVES.
  - Undefined bits read 0.
- m_wb_rst_o = RST_CTRL[NO_OF_SLAVES-1:0], forced all-ones while wb_rst_i is low.
- irq_o is registered: IRQ_EN[0] & |STATUS.

## Timing
- **Reset values**: wbs_ack_o=0, wbs_dat_o=0, m_wbs_stb_o=0, irq_o=0, state IDLE, counter 0, STATUS 0, IRQ_EN 0, RST_CTRL 0. m_wb_rst_o is all-ones while reset is asserted.
- **Latency**: request sampled at cycle 0, strobe at cycle 1, slave ack at cycle k, wbs_ack_o at cycle k+1.
  - CSR and unmapped accesses ack at cycle 2.
  - A timeout acks at cycle 2^TMO_WIDTH+1.
- **Abort**: if cyc or stb drops during WAIT, strobe drops that cycle, the FSM returns to IDLE, no ack is issued and STATUS is unchanged.
- Slave ack and counter reaching the limit in the same cycle: the ack wins and no status bit is set.
- The counter clears on entering WAIT.
- Acks from non-selected slaves are ignored.
- If stb is still high in the cycle after RESP, a new transfer starts.
- A STATUS W1C write in the same cycle as a timeout set on the same bit: the set wins.
- Reset assertion mid-transfer returns to IDLE immediately with no ack.

## Structure
- Package ren_wb_pkg holds:
  - FSM state enum;
  - CSR offset constants;
  - ID constant 32'h5245_4E00;
  - error data constants 32'hDEAD_0000 and 32'hBADA_DD00.
- Sub-module ren_wb_csr holds RST_CTRL, STATUS, IRQ_EN, ID and irq_o. The top level keeps the FSM, decode, timeout counter and response mux.

## Test plan
- Read slave 3 (adr 32'h0003_0000) with ack at cycle 4 and data 32'h1234_5678 -> m_wbs_stb_o = 11'b000_0000_1000 during cycles 1-4; wbs_ack_o high at cycle 5 only; wbs_dat_o = 32'h1234_5678.
- Slave 7 never acks, TMO_WIDTH=8 -> ack at cycle 257 with data 32'hDEAD_0007; STATUS bit 7 set; irq_o=1 the following cycle when IRQ_EN=1; W1C of 32'h80 clears it and irq_o returns to 0.
- Write RST_CTRL = 32'h0000_0005 with sel=4'b0001 -> m_wb_rst_o = 11'b000_0000_0101; a read returns 5; a read of ID returns 32'h5245_4E0B.
- Access slot 12 (unmapped) -> no strobe; ack at cycle 2 with data 32'hBADA_DD00; a write there changes no state.
- Drop cyc at cycle 2 of a slave-1 transfer -> strobe low in the same cycle, no ack, STATUS stays 0; the next transfer completes normally.
- Assert wb_rst_i low during WAIT -> all outputs return to their reset values asynchronously; m_wb_rst_o is all-ones until release, then 0.

Source files
------------

// File: rtl/ren_wb_slave_fanout_pkg.sv
// Shared types and constants for the Wishbone slave fan-out.
package ren_wb_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_e;

  // CSR word offsets (wbs_adr_i[3:2]) inside the CSR slot
  localparam logic [1:0] CSR_RST_CTRL = 2'd0;
  localparam logic [1:0] CSR_STATUS   = 2'd1;
  localparam logic [1:0] CSR_IRQ_EN   = 2'd2;
  localparam logic [1:0] CSR_ID       = 2'd3;

  // Identification and error response patterns
  localparam logic [31:0] REN_ID_BASE       = 32'h5245_4E00;
  localparam logic [31:0] ERR_TMO_DATA      = 32'hDEAD_0000;
  localparam logic [31:0] ERR_UNMAPPED_DATA = 32'hBADA_DD00;

  // Expand the four byte selects into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/ren_wb_slave_fanout_if.sv
// Host-side Wishbone port plus the downstream slave bundle of the fan-out.
// cyc/we/sel/dat/adr are shared by every slave; only the strobe is per slave.
interface ren_wb_slave_fanout_if #(
  parameter int NO_OF_SLAVES = 11
);
  logic                        wbs_cyc_i;
  logic                        wbs_stb_i;
  logic                        wbs_we_i;
  logic [3:0]                  wbs_sel_i;
  logic [31:0]                 wbs_dat_i;
  logic [31:0]                 wbs_adr_i;
  logic                        wbs_ack_o;
  logic [31:0]                 wbs_dat_o;
  logic [NO_OF_SLAVES-1:0]     m_wbs_stb_o;
  logic [NO_OF_SLAVES-1:0]     m_wb_rst_o;
  logic [NO_OF_SLAVES-1:0]     m_wbs_ack_i;
  logic [32*NO_OF_SLAVES-1:0]  m_wbs_dat_i;
  logic                        irq_o;

  // Seen from the fan-out itself
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  m_wbs_ack_i, m_wbs_dat_i,
    output wbs_ack_o, wbs_dat_o, m_wbs_stb_o, m_wb_rst_o, irq_o
  );

  // Seen from the host / environment driving the fan-out
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output m_wbs_ack_i, m_wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o, m_wbs_stb_o, m_wb_rst_o, irq_o
  );
endinterface

// File: rtl/ren_wb_slave_fanout_csr.sv
// Local control/status registers: per-slave soft reset, sticky timeout
// status (write-1-to-clear), interrupt enable, ID and the interrupt line.
module ren_wb_csr
  import ren_wb_pkg::*;
#(
  parameter int NO_OF_SLAVES = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [1:0]              offset,
  input  logic [31:0]             wdata,
  input  logic [3:0]              sel,
  input  logic [NO_OF_SLAVES-1:0] tmo_set,
  output logic [31:0]             rdata,
  output logic [NO_OF_SLAVES-1:0] rst_ctrl,
  output logic                    irq
);

  logic [NO_OF_SLAVES-1:0] rst_ctrl_r;
  logic [NO_OF_SLAVES-1:0] status_r;
  logic                    irq_en_r;
  logic                    irq_r;
  logic [31:0]             bmask_s;
  logic [31:0]             wbits_s;
  logic [NO_OF_SLAVES-1:0] status_clr_s;
  logic                    unused_wbits_s;

  assign bmask_s        = byte_mask(sel);
  assign wbits_s        = wdata & bmask_s;
  assign unused_wbits_s = ^{wbits_s[31:NO_OF_SLAVES], bmask_s[31:NO_OF_SLAVES]};

  // Bits of STATUS cleared by a W1C write this cycle
  always_comb begin
    status_clr_s = '0;
    if (wr_en && (offset == CSR_STATUS)) begin
      status_clr_s = wbits_s[NO_OF_SLAVES-1:0];
    end else begin
      status_clr_s = '0;
    end
  end

  // RST_CTRL: byte-masked write of the per-slave soft reset bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_ctrl_r <= '0;
    end else if (wr_en && (offset == CSR_RST_CTRL)) begin
      rst_ctrl_r <= (rst_ctrl_r & ~bmask_s[NO_OF_SLAVES-1:0]) | wbits_s[NO_OF_SLAVES-1:0];
    end
  end

  // STATUS: sticky timeout flags; a simultaneous timeout set beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_r <= '0;
    end else begin
      status_r <= (status_r & ~status_clr_s) | tmo_set;
    end
  end

  // IRQ_EN: single enable bit in byte 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_r <= 1'b0;
    end else if (wr_en && (offset == CSR_IRQ_EN) && sel[0]) begin
      irq_en_r <= wdata[0];
    end
  end

  // Registered interrupt: enabled and any slave has timed out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en_r & (|status_r);
    end
  end

  // Read mux; undefined bits read as zero
  always_comb begin
    rdata = 32'd0;
    case (offset)
      CSR_RST_CTRL: rdata = 32'(rst_ctrl_r);
      CSR_STATUS:   rdata = 32'(status_r);
      CSR_IRQ_EN:   rdata = {31'd0, irq_en_r};
      CSR_ID:       rdata = REN_ID_BASE | 32'(NO_OF_SLAVES);
      default:      rdata = 32'd0;
    endcase
  end

  assign rst_ctrl = rst_ctrl_r;
  assign irq      = irq_r;

endmodule

// File: rtl/ren_wb_slave_fanout.sv
// Wishbone fan-out: routes each host transfer to one of NO_OF_SLAVES slaves
// by address slot, registers the response, times out silent slaves and
// hosts a local CSR slot in the top slot.
module ren_wb_slave_fanout
  import ren_wb_pkg::*;
#(
  parameter int NO_OF_SLAVES  = 11,
  parameter int SLV_SEL_LSB   = 16,
  parameter int SLV_SEL_WIDTH = 4,
  parameter int TMO_WIDTH     = 8
) (
  input logic                   wb_clk_i,
  input logic                   wb_rst_i,
  ren_wb_slave_fanout_if.slave  bus
);

  localparam logic [SLV_SEL_WIDTH-1:0] CSR_SLOT  = '1;
  localparam logic [SLV_SEL_WIDTH-1:0] NUM_SLOTS = SLV_SEL_WIDTH'(NO_OF_SLAVES);
  localparam logic [TMO_WIDTH-1:0]     TMO_LIMIT = '1;

  fsm_state_e               state_r;
  logic [SLV_SEL_WIDTH-1:0] slot_r;
  logic [TMO_WIDTH-1:0]     tmo_cnt_r;
  logic                     ack_r;
  logic [31:0]              dat_r;

  logic                     req_s;
  logic                     active_s;
  logic [SLV_SEL_WIDTH-1:0] slot_s;
  logic                     is_slave_s;
  logic                     is_csr_s;
  logic                     sel_ack_s;
  logic [31:0]              sel_dat_s;
  logic [NO_OF_SLAVES-1:0]  stb_s;
  logic [NO_OF_SLAVES-1:0]  tmo_set_s;
  logic                     slave_ack_s;
  logic                     tmo_hit_s;
  logic                     go_resp_s;
  logic                     csr_wr_s;
  logic [31:0]              csr_rdata_s;
  logic [31:0]              resp_dat_s;
  logic [NO_OF_SLAVES-1:0]  rst_ctrl_s;
  logic                     irq_s;
  logic                     unused_adr_s;

  assign req_s        = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign slot_s       = bus.wbs_adr_i[SLV_SEL_LSB +: SLV_SEL_WIDTH];
  assign active_s     = (state_r == ST_WAIT) && req_s;
  assign is_slave_s   = (slot_r < NUM_SLOTS);
  assign is_csr_s     = (slot_r == CSR_SLOT);
  assign unused_adr_s = ^bus.wbs_adr_i;

  // Per-slave decode: strobe, timeout flag and selected ack/data
  always_comb begin
    sel_ack_s = 1'b0;
    sel_dat_s = 32'd0;
    stb_s     = '0;
    tmo_set_s = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (slot_r == SLV_SEL_WIDTH'(i)) begin
        sel_ack_s    = bus.m_wbs_ack_i[i];
        sel_dat_s    = bus.m_wbs_dat_i[32*i +: 32];
        stb_s[i]     = active_s;
        tmo_set_s[i] = tmo_hit_s;
      end else begin
        stb_s[i]     = 1'b0;
        tmo_set_s[i] = 1'b0;
      end
    end
  end

  // A slave ack beats the timeout when both happen in the same cycle
  assign slave_ack_s = active_s && is_slave_s && sel_ack_s;
  assign tmo_hit_s   = active_s && is_slave_s && !sel_ack_s && (tmo_cnt_r == TMO_LIMIT);
  assign go_resp_s   = slave_ack_s || tmo_hit_s || (active_s && !is_slave_s);
  assign csr_wr_s    = active_s && is_csr_s && bus.wbs_we_i;

  // Response data for the transfer completing this cycle
  always_comb begin
    resp_dat_s = 32'd0;
    if (is_slave_s) begin
      if (slave_ack_s) begin
        resp_dat_s = sel_dat_s;
      end else begin
        resp_dat_s = ERR_TMO_DATA | 32'(slot_r);
      end
    end else if (is_csr_s) begin
      resp_dat_s = csr_rdata_s;
    end else begin
      resp_dat_s = ERR_UNMAPPED_DATA;
    end
  end

  // Transfer FSM with registered ack/data, latched slot and timeout counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_r   <= ST_IDLE;
      slot_r    <= '0;
      tmo_cnt_r <= '0;
      ack_r     <= 1'b0;
      dat_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          if (req_s) begin
            slot_r    <= slot_s;
            tmo_cnt_r <= '0;
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req_s) begin
            state_r <= ST_IDLE;
          end else if (go_resp_s) begin
            state_r <= ST_RESP;
            ack_r   <= 1'b1;
            dat_r   <= resp_dat_s;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_WIDTH'(1);
          end
        end
        ST_RESP: begin
          ack_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  ren_wb_csr #(
    .NO_OF_SLAVES (NO_OF_SLAVES)
  ) u_csr (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .wr_en    (csr_wr_s),
    .offset   (bus.wbs_adr_i[3:2]),
    .wdata    (bus.wbs_dat_i),
    .sel      (bus.wbs_sel_i),
    .tmo_set  (tmo_set_s),
    .rdata    (csr_rdata_s),
    .rst_ctrl (rst_ctrl_s),
    .irq      (irq_s)
  );

  assign bus.wbs_ack_o   = ack_r;
  assign bus.wbs_dat_o   = dat_r;
  assign bus.m_wbs_stb_o = stb_s;
  assign bus.irq_o       = irq_s;
  // Slaves are held in reset for as long as the fan-out itself is
  assign bus.m_wb_rst_o  = rst_ctrl_s | {NO_OF_SLAVES{~wb_rst_i}};

endmodule
